// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
// Line states are encoded as {d_plus, d_minus}.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_DATA,
      ST_EOP,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } line_t;

   typedef enum logic [3:0] {
      PID_OUT   = 4'h1,
      PID_IN    = 4'h9,
      PID_SOF   = 4'h5,
      PID_SETUP = 4'hD,
      PID_DATA0 = 4'h3,
      PID_DATA1 = 4'hB,
      PID_ACK   = 4'h2,
      PID_NAK   = 4'hA,
      PID_STALL = 4'hE
   } pid_t;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;

   function automatic logic pid_ok(input logic [7:0] p);
      return p[7:4] == ~p[3:0];
   endfunction

endpackage

// File: rtl/usb_rx_if.sv
// Bus lines in, decoded packet events out.
// master = decoder side, slave = downstream consumer.
interface usb_rx_if;

   logic       d_plus;
   logic       d_minus;
   logic       rx_active;
   logic [3:0] rx_pid;
   logic       rx_pid_valid;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_eop;
   logic       rx_error;

   modport master (
      input  d_plus,
      input  d_minus,
      output rx_active,
      output rx_pid,
      output rx_pid_valid,
      output rx_data,
      output rx_data_valid,
      output rx_eop,
      output rx_error
   );

   modport slave (
      output d_plus,
      output d_minus,
      input  rx_active,
      input  rx_pid,
      input  rx_pid_valid,
      input  rx_data,
      input  rx_data_valid,
      input  rx_eop,
      input  rx_error
   );

endinterface

// File: rtl/usb_rx_bit_timer.sv
// Bit-phase recovery: d_plus edge detect, reloadable bit counter,
// and a sample strobe at a fixed point inside each bit cell.
module usb_rx_bit_timer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_PT    = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic dp_s,
   output logic edge_det,
   output logic sample
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic          dp_q;
   logic [CW-1:0] cnt;

   assign edge_det = dp_s ^ dp_q;
   assign sample   = (cnt == CW'(SAMPLE_PT));

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         dp_q <= 1'b1;
         cnt  <= '0;
      end else begin
         dp_q <= dp_s;
         if (edge_det || cnt == CW'(CLKS_PER_BIT - 1))
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder: sync, NRZI decode, unstuffing,
// SYNC/PID checks and per-byte strobes to downstream logic.
module usb_rx_decoder
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_PT    = 3,
   parameter int MAX_BYTES    = 10
) (
   input logic      clk,
   input logic      n_rst,
   usb_rx_if.master bus
);

   localparam int BW = $clog2(MAX_BYTES + 2);

   logic [1:0]    dp_sync, dm_sync;
   logic          dp_s, dm_s;
   logic          edge_det, sample;
   line_t         line, prev;
   state_t        state;
   logic [6:0]    sr;
   logic [7:0]    shifted;
   logic [2:0]    bitcnt, ones, jcnt;
   logic [BW-1:0] bytecnt;
   logic          se0_seen, bit_in, stuff, fault;
   logic          active_q, pid_v_q, data_v_q, eop_q, err_q;
   logic [3:0]    pid_q;
   logic [7:0]    data_q;

   assign dp_s    = dp_sync[1];
   assign dm_s    = dm_sync[1];
   assign line    = line_t'({dp_s, dm_s});
   assign bit_in  = (line == prev);
   assign stuff   = (ones == 3'd6);
   assign shifted = {bit_in, sr};

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         dp_sync <= 2'b11;
         dm_sync <= 2'b00;
      end else begin
         dp_sync <= {dp_sync[0], bus.d_plus};
         dm_sync <= {dm_sync[0], bus.d_minus};
      end
   end

   usb_rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SAMPLE_PT    (SAMPLE_PT)
   ) u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .dp_s     (dp_s),
      .edge_det (edge_det),
      .sample   (sample)
   );

   // Every protocol violation on a sample, gathered in one place
   always_comb begin
      fault = 1'b0;
      if (sample) begin
         case (state)
            ST_SYNC, ST_PID, ST_DATA: begin
               if (line == LS_SE1)
                  fault = 1'b1;
               else if (line == LS_SE0)
                  fault = !(state == ST_DATA &&
                            (bitcnt == 3'd0 || stuff));
               else if (stuff)
                  fault = bit_in;
               else if (bitcnt == 3'd7) begin
                  case (state)
                     ST_SYNC: fault = (shifted != SYNC_PATTERN);
                     ST_PID:  fault = !pid_ok(shifted);
                     default: fault = (bytecnt == BW'(MAX_BYTES));
                  endcase
               end
            end
            ST_EOP:
               fault = se0_seen ? (line != LS_J) : (line != LS_SE0);
            default:
               fault = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         prev     <= LS_J;
         sr       <= '0;
         bitcnt   <= '0;
         ones     <= '0;
         jcnt     <= '0;
         bytecnt  <= '0;
         se0_seen <= 1'b0;
         active_q <= 1'b0;
         pid_v_q  <= 1'b0;
         data_v_q <= 1'b0;
         eop_q    <= 1'b0;
         err_q    <= 1'b0;
         pid_q    <= '0;
         data_q   <= '0;
      end else begin
         pid_v_q  <= 1'b0;
         data_v_q <= 1'b0;
         eop_q    <= 1'b0;
         err_q    <= 1'b0;
         if (fault) begin
            state    <= ST_ERR;
            err_q    <= 1'b1;
            se0_seen <= (line == LS_SE0);
            jcnt     <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (edge_det && line == LS_K) begin
                     state    <= ST_SYNC;
                     active_q <= 1'b1;
                     prev     <= LS_J;
                     bitcnt   <= '0;
                     ones     <= '0;
                     bytecnt  <= '0;
                     se0_seen <= 1'b0;
                  end
               end
               ST_SYNC, ST_PID, ST_DATA: begin
                  if (sample) begin
                     if (line == LS_SE0) begin
                        state    <= ST_EOP;
                        se0_seen <= 1'b0;
                     end else begin
                        prev <= line;
                        if (stuff) begin
                           ones <= '0;
                        end else begin
                           ones   <= bit_in ? ones + 3'd1 : 3'd0;
                           sr     <= shifted[7:1];
                           bitcnt <= bitcnt + 3'd1;
                           if (bitcnt == 3'd7) begin
                              case (state)
                                 ST_SYNC: state <= ST_PID;
                                 ST_PID: begin
                                    pid_q   <= shifted[3:0];
                                    pid_v_q <= 1'b1;
                                    bytecnt <= '0;
                                    state   <= ST_DATA;
                                 end
                                 default: begin
                                    data_q   <= shifted;
                                    data_v_q <= 1'b1;
                                    bytecnt  <= bytecnt + BW'(1);
                                 end
                              endcase
                           end
                        end
                     end
                  end
               end
               ST_EOP: begin
                  if (sample) begin
                     if (se0_seen) begin
                        eop_q    <= 1'b1;
                        active_q <= 1'b0;
                        prev     <= LS_J;
                        state    <= ST_IDLE;
                     end else begin
                        se0_seen <= 1'b1;
                     end
                  end
               end
               ST_ERR: begin
                  // Leave on SE0 then J, or after eight idle J cells
                  if (sample) begin
                     if (line == LS_J) begin
                        if (se0_seen || jcnt == 3'd7) begin
                           active_q <= 1'b0;
                           prev     <= LS_J;
                           state    <= ST_IDLE;
                        end else begin
                           jcnt <= jcnt + 3'd1;
                        end
                     end else begin
                        jcnt     <= '0;
                        se0_seen <= (line == LS_SE0);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.rx_active     = active_q;
   assign bus.rx_pid        = pid_q;
   assign bus.rx_pid_valid  = pid_v_q;
   assign bus.rx_data       = data_q;
   assign bus.rx_data_valid = data_v_q;
   assign bus.rx_eop        = eop_q;
   assign bus.rx_error      = err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI/stuffing line encoder,
// strobe monitor, and immediate-assertion checks per step.
module tb_usb_rx_decoder;

   logic clk = 1'b0;
   logic n_rst;

   always #5 clk = ~clk;

   usb_rx_if bus ();

   usb_rx_decoder #(
      .CLKS_PER_BIT (8),
      .SAMPLE_PT    (3),
      .MAX_BYTES    (10)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.master)
   );

   int tests = 0;
   int fails = 0;

   int n_pid = 0, n_data = 0, n_eop = 0, n_err = 0, n_multi = 0;
   logic [7:0] dlog [0:63];

   always @(negedge clk) begin
      if ($countones({bus.rx_pid_valid, bus.rx_data_valid,
                      bus.rx_eop, bus.rx_error}) > 1)
         n_multi++;
      if (bus.rx_pid_valid === 1'b1) n_pid++;
      if (bus.rx_data_valid === 1'b1) begin
         if (n_data < 64) dlog[n_data] = bus.rx_data;
         n_data++;
      end
      if (bus.rx_eop === 1'b1) n_eop++;
      if (bus.rx_error === 1'b1) n_err++;
   end

   logic cur_dp;
   int   ones_tx;
   int   s_pid, s_data, s_eop, s_err;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold_line(input logic dp, input logic dm);
      bus.d_plus  = dp;
      bus.d_minus = dm;
      repeat (8) @(posedge clk);
   endtask

   task automatic tx_bit(input logic b, input bit stuff_en);
      if (!b) cur_dp = ~cur_dp;
      hold_line(cur_dp, ~cur_dp);
      if (stuff_en) begin
         if (b) ones_tx++;
         else ones_tx = 0;
         if (ones_tx == 6) begin
            cur_dp = ~cur_dp;
            hold_line(cur_dp, ~cur_dp);
            ones_tx = 0;
         end
      end
   endtask

   task automatic tx_byte(input logic [7:0] v, input bit stuff_en);
      for (int i = 0; i < 8; i++) tx_bit(v[i], stuff_en);
   endtask

   task automatic tx_sync();
      cur_dp  = 1'b1;
      ones_tx = 0;
      tx_byte(8'h80, 1'b1);
   endtask

   task automatic tx_eop();
      hold_line(1'b0, 1'b0);
      hold_line(1'b0, 1'b0);
      cur_dp = 1'b1;
      hold_line(1'b1, 1'b0);
      hold_line(1'b1, 1'b0);
   endtask

   task automatic snap();
      s_pid  = n_pid;
      s_data = n_data;
      s_eop  = n_eop;
      s_err  = n_err;
   endtask

   function automatic logic [3:0] strobes();
      return {bus.rx_pid_valid, bus.rx_data_valid,
              bus.rx_eop, bus.rx_error};
   endfunction

   initial begin
      int bad;
      bus.d_plus  = 1'b1;
      bus.d_minus = 1'b0;
      cur_dp      = 1'b1;
      ones_tx     = 0;
      n_rst       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_active", 32'(bus.rx_active), 32'h0);
      chk("rst_pid", 32'(bus.rx_pid), 32'h0);
      chk("rst_data", 32'(bus.rx_data), 32'h0);
      chk("rst_strobes", 32'(strobes()), 32'h0);

      n_rst = 1'b1;
      bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (bus.rx_active !== 1'b0 || strobes() !== 4'h0) bad++;
      end
      chk("idle_quiet", 32'(bad), 32'h0);

      // ACK handshake packet
      snap();
      tx_sync();
      tx_byte(8'hD2, 1'b1);
      tx_eop();
      chk("ack_pid_cnt", 32'(n_pid - s_pid), 32'd1);
      chk("ack_pid", 32'(bus.rx_pid), 32'h2);
      chk("ack_eop_cnt", 32'(n_eop - s_eop), 32'd1);
      chk("ack_data_cnt", 32'(n_data - s_data), 32'd0);
      chk("ack_err_cnt", 32'(n_err - s_err), 32'd0);

      // DATA0 with stuffed runs of ones
      snap();
      tx_sync();
      tx_byte(8'hC3, 1'b1);
      tx_byte(8'hFF, 1'b1);
      tx_byte(8'hFF, 1'b1);
      tx_byte(8'h3C, 1'b1);
      tx_eop();
      chk("d0_data_cnt", 32'(n_data - s_data), 32'd3);
      chk("d0_byte0", 32'(dlog[s_data]), 32'hFF);
      chk("d0_byte1", 32'(dlog[s_data + 1]), 32'hFF);
      chk("d0_byte2", 32'(dlog[s_data + 2]), 32'h3C);
      chk("d0_err_cnt", 32'(n_err - s_err), 32'd0);
      chk("d0_eop_cnt", 32'(n_eop - s_eop), 32'd1);

      // Missing stuff bit after six ones
      snap();
      tx_sync();
      tx_byte(8'h4B, 1'b1);
      repeat (7) tx_bit(1'b1, 1'b0);
      tx_eop();
      chk("stf_err_cnt", 32'(n_err - s_err), 32'd1);
      chk("stf_data_cnt", 32'(n_data - s_data), 32'd0);
      chk("stf_eop_cnt", 32'(n_eop - s_eop), 32'd0);
      chk("stf_active", 32'(bus.rx_active), 32'h0);

      // PID check nibble mismatch
      snap();
      tx_sync();
      tx_byte(8'hD3, 1'b1);
      tx_eop();
      chk("bpid_err_cnt", 32'(n_err - s_err), 32'd1);
      chk("bpid_pid_cnt", 32'(n_pid - s_pid), 32'd0);
      chk("bpid_eop_cnt", 32'(n_eop - s_eop), 32'd0);

      // Eleven data bytes: the eleventh overflows
      snap();
      tx_sync();
      tx_byte(8'hC3, 1'b1);
      for (int i = 0; i < 11; i++) tx_byte(8'h10 + 8'(i), 1'b1);
      tx_eop();
      chk("ovf_data_cnt", 32'(n_data - s_data), 32'd10);
      chk("ovf_err_cnt", 32'(n_err - s_err), 32'd1);
      chk("ovf_eop_cnt", 32'(n_eop - s_eop), 32'd0);
      chk("ovf_last", 32'(bus.rx_data), 32'h19);

      // Reset pulse during the second data byte
      tx_sync();
      tx_byte(8'hC3, 1'b1);
      tx_byte(8'h55, 1'b1);
      chk("mid_data", 32'(bus.rx_data), 32'h55);
      tx_bit(1'b1, 1'b1);
      tx_bit(1'b0, 1'b1);
      tx_bit(1'b1, 1'b1);
      #1;
      n_rst       = 1'b0;
      bus.d_plus  = 1'b1;
      bus.d_minus = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_active", 32'(bus.rx_active), 32'h0);
      chk("mrst_pid", 32'(bus.rx_pid), 32'h0);
      chk("mrst_data", 32'(bus.rx_data), 32'h0);
      chk("mrst_strobes", 32'(strobes()), 32'h0);
      n_rst = 1'b1;
      snap();
      repeat (160) @(posedge clk);
      chk("mrst_quiet",
          32'((n_pid - s_pid) + (n_data - s_data) +
              (n_eop - s_eop) + (n_err - s_err)), 32'd0);

      snap();
      tx_sync();
      tx_byte(8'hD2, 1'b1);
      tx_eop();
      chk("ack2_pid_cnt", 32'(n_pid - s_pid), 32'd1);
      chk("ack2_pid", 32'(bus.rx_pid), 32'h2);
      chk("ack2_eop_cnt", 32'(n_eop - s_eop), 32'd1);
      chk("ack2_err_cnt", 32'(n_err - s_err), 32'd0);

      chk("one_hot_strobes", 32'(n_multi), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usb_rx_decoder.md
# usb_rx_decoder

Receive-side USB full-speed packet decoder, the counterpart of the USB transmit path. It takes the differential bus lines, recovers bit timing by oversampling, and decodes NRZI. It removes stuffed bits, checks SYNC and PID, and emits the PID plus one strobe per data byte to the downstream packet/CRC logic. CRC5/CRC16 bytes pass through as ordinary data bytes; CRC checking is done downstream.

## Interface
Parameters:
- CLKS_PER_BIT, 8, clk cycles per bus bit.
- SAMPLE_PT, 3, bit-timer count at which the line is sampled.
- MAX_BYTES, 10, maximum data bytes after the PID (8 payload + 2 CRC16).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- d_plus  in  1  bus D+, asynchronous to clk.
- d_minus  in  1  bus D−, asynchronous to clk.
- rx_active  out  1  packet in progress.
- rx_pid  out  4  last valid PID (low nibble).
- rx_pid_valid  out  1  one-cycle strobe; rx_pid is updated.
- rx_data  out  8  last received byte, LSB = first bit on the wire.
- rx_data_valid  out  1  one-cycle strobe; rx_data is updated.
- rx_eop  out  1  one-cycle strobe on a clean EOP.
- rx_error  out  1  one-cycle strobe on any protocol error.

## Operation
- **Synchronizer:** two flops per line; reset values d_plus=1, d_minus=0 (J).
- **Line state at each sample:**
  - J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
  - SE1 while rx_active is an error.
- **Bit timer:** counts 0..CLKS_PER_BIT−1 and wraps. It reloads to 0 on every transition of synchronized d_plus. A sample is taken when count == SAMPLE_PT.
- **NRZI decode:** bit = 1 if the sampled line equals the previous sample, else 0. The previous sample resets to J and is forced back to J on return to IDLE.
- **Unstuffing:** counts consecutive decoded 1s.
  - After six 1s, the next bit is dropped and the counter clears.
  - If that bit is 1, it is a stuff error.
  - SE0 in the stuff-bit slot takes priority (treated as EOP).
- **FSM states:** IDLE, SYNC, PID, DATA, EOP, ERR.
  - IDLE: J→K on synchronized d_plus → SYNC, timer reloads.
  - SYNC: 8 bits shifted LSB-first must equal 8'h80. Mismatch → ERR.
  - PID: 8 bits; valid if pid[7:4] == ~pid[3:0]. Valid → latch rx_pid, strobe rx_pid_valid, go to DATA. Invalid → ERR.
  - DATA:
    - Every 8 unstuffed bits → latch rx_data and strobe rx_data_valid.
    - SE0 on a byte boundary → EOP.
    - SE0 mid-byte → ERR.
    - Byte count reaching MAX_BYTES+1 → ERR, and the overflowing byte is not strobed.
  - EOP: requires a second SE0 sample, then a J sample. Then strobe rx_eop and go to IDLE. Any other sequence → ERR.
  - ERR: rx_error strobes once on entry. Stay until SE0 followed by J, or 8 consecutive J samples; then go to IDLE with no rx_eop.
- rx_active is 1 in every state except IDLE.

## Timing
- Reset values:
  - rx_active, rx_pid_valid, rx_data_valid, rx_eop, rx_error = 0.
  - rx_pid = 0, rx_data = 0.
  - State = IDLE; bit timer, byte count and ones count = 0.
- Input-to-state latency: 2 cycles (synchronizer) plus 1 cycle for edge detect.
- rx_pid_valid and rx_data_valid assert the cycle after the sample that completes the byte. The strobe is exactly 1 cycle; rx_pid and rx_data hold their values until the next strobe.
- rx_eop asserts the cycle after the terminating J sample; rx_active falls in that same cycle.
- When a byte completes and the following slot is a stuff bit, the byte strobe is not delayed.
- At most one strobe of rx_pid_valid, rx_data_valid, rx_eop and rx_error is high in any cycle.
- Reset mid-packet: all outputs are at reset values the cycle after the sampled n_rst=0. No strobes are emitted for the partial packet.

## Structure
- usb_rx_pkg holds:
  - State enum.
  - Line-state enum (J, K, SE0, SE1).
  - SYNC_PATTERN = 8'h80.
  - PID nibble constants (OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL).
- Sub-module usb_rx_bit_timer contains the edge detector, the reloadable counter and the sample strobe. The FSM, NRZI decode, unstuffing and shift register live in usb_rx_decoder.

## Test plan
- **Reset, then idle J for 100 cycles:** all outputs 0, rx_active stays 0.
- **SYNC + ACK PID (0xD2) + EOP:** rx_pid = 4'h2 with one rx_pid_valid strobe; one rx_eop strobe; no rx_data_valid; no rx_error.
- **SYNC + DATA0 PID (0xC3) + bytes 0xFF, 0xFF, 0x3C with stuffed zeros + EOP:** rx_data_valid strobes 3 times with values 0xFF, 0xFF, 0x3C; no rx_error.
- **Seven consecutive 1s (missing stuff bit) inside a data byte:** one rx_error strobe; no rx_data_valid for that byte; rx_active low after the following EOP.
- **PID 0xD3 (check fails), and separately 11 data bytes with MAX_BYTES=10:** rx_error strobes once in each case; no rx_pid_valid for the bad PID; exactly 10 rx_data_valid strobes in the overflow case.
- **n_rst low for 1 cycle during the 2nd data byte, then a clean ACK packet:** outputs are at reset values the next cycle; the ACK is decoded normally with rx_pid = 4'h2.
